uart_result_streamer: RTL and testbench
=======================================

// Module: uart_result_streamer
// PURPOSE
//  Sequences the UART Transmitter to stream a finished result tile out of the result buffer.
//  On start, reads ROWS*COLS elements from a 1-cycle-latency RAM, row-major.
//  Frames them as: SYNC byte, data bytes (each element MSB byte first), XOR checksum byte.
//  Drives the Transmitter's d_in/load and paces on its tx_status.
//  Sits between the matmul result buffer and the Transmitter.
// PARAMETERS
//  ROWS        4      rows in result tile (>=1)
//  COLS        4      columns in result tile (>=1)
//  ELEM_W      16     element width, bits; multiple of 8
//  ADDR_W      8      result RAM address width; ROWS*COLS <= 2**ADDR_W
//  BASE_ADDR   0      RAM address of element (0,0)
//  SYNC_BYTE   8'hA5  frame header byte
// PORTS
//  clk        in   1         system clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  start      in   1         1-cycle pulse: begin streaming one tile
//  abort      in   1         1-cycle pulse: abandon current frame
//  busy       out  1         high from accepted start until done/abort
//  done       out  1         1-cycle pulse after the checksum byte is fully sent
//  mem_rd_en  out  1         RAM read strobe
//  mem_addr   out  ADDR_W    RAM read address
//  mem_rdata  in   ELEM_W    RAM data, valid the cycle after mem_rd_en
//  tx_data    out  8         to Transmitter d_in; held stable while tx_load is high
//  tx_load    out  1         to Transmitter load; exactly 1-cycle pulse per byte
//  tx_status  in   1         from Transmitter; 1 = ready for a new byte
// BEHAVIOUR
//  Reset: state IDLE. busy=0, done=0, mem_rd_en=0, mem_addr=BASE_ADDR, tx_load=0, tx_data=0.
//    Element counter = 0. Byte index = 0. Checksum = 0.
//  States: IDLE, LOAD_HDR, FETCH, CAPTURE, LOAD_BYTE, WAIT_BUSY, WAIT_RDY, LOAD_CSUM, FINISH.
//  IDLE: start=1 -> LOAD_HDR; busy=1 next cycle; counters and checksum cleared.
//  LOAD_*: entered only when tx_status=1, else held there.
//    Issue tx_load=1 for one cycle with tx_data set, then go to WAIT_BUSY.
//    Each state's tx_data: LOAD_HDR = SYNC_BYTE; LOAD_BYTE = current byte; LOAD_CSUM = checksum.
//  WAIT_BUSY: wait for tx_status=0 (Transmitter has taken the byte), then WAIT_RDY.
//  WAIT_RDY: wait for tx_status=1, then pick next state.
//    Next state: remaining bytes of current element -> LOAD_BYTE;
//    else elements remaining -> FETCH; else, if checksum not yet sent, -> LOAD_CSUM; else FINISH.
//    The byte just after the header is always reached via FETCH.
//  FETCH: mem_rd_en=1 for one cycle, mem_addr=BASE_ADDR+elem_cnt, then CAPTURE.
//  CAPTURE: register mem_rdata into the element shift register, then LOAD_BYTE.
//  Byte order: ELEM_W/8 bytes per element, MSB byte first.
//  Checksum: 8-bit XOR of all data bytes only; SYNC byte excluded; updated as each byte is loaded.
//  FINISH: done=1 for one cycle, busy=0, back to IDLE. No RAM read beyond the last element.
//  Frame length: 2 + ROWS*COLS*ELEM_W/8 bytes.
//  Latency: start -> first tx_load is 1 cycle, provided tx_status=1.
//  Boundaries:
//   start while busy=1: ignored.
//   start and abort in the same cycle while IDLE: start wins.
//   abort while busy: next cycle enters IDLE, busy=0, done not pulsed, tx_load=0.
//     A byte already loaded finishes in the Transmitter; it is not recalled.
//   abort in the same cycle as an active tx_load pulse: the pulse completes; no further load.
//   reset low mid-frame: immediately forces all outputs to their reset values.
//   tx_status stuck 0: the block waits indefinitely; abort or reset exits.
//   elem_cnt reaching ROWS*COLS-1: last fetch; the counter never wraps into other addresses.
// TESTING
//  T1 Defaults (4x4, 16-bit), RAM[i]=16'h0100*i+i, Transmitter model:
//     -> 34 bytes: A5, 00 00, 01 01, ..., 0F 0F, checksum 00; done pulses once; busy low after.
//  T2 ROWS=1, COLS=1, ELEM_W=8, RAM[0]=8'h3C
//     -> bytes A5, 3C, 3C; mem_rd_en pulsed exactly once at addr BASE_ADDR.
//  T3 Second start pulse after byte 5 of T1
//     -> ignored; frame identical to T1; exactly one done pulse.
//  T4 abort during 3rd data byte transmission
//     -> busy=0 next cycle, no done pulse, no further tx_load.
//     Then a new start gives a complete correct frame.
//  T5 Reset asserted low during WAIT_RDY
//     -> all outputs immediately 0 (mem_addr=BASE_ADDR); after release, IDLE ignores a stale tx_status.
//  T6 Hold tx_status=0 for 100 cycles before the header
//     -> tx_load stays 0; the load is issued 1 cycle after tx_status rises; tx_data stable during the load.

Source files
------------

// File: rtl/uart_result_streamer.sv
// uart_result_streamer
//   Streams a finished result tile from the result RAM to the UART
//   Transmitter. A frame is the SYNC byte, then every element of the
//   tile in row-major order (each element MSB byte first), then an
//   8-bit XOR checksum over the data bytes.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      1-cycle pulse, begin one frame (ignored while busy)
//   abort      1-cycle pulse, abandon the current frame
//   busy       high from accepted start until done/abort
//   done       1-cycle pulse after the checksum byte has been sent
//   mem_rd_en  result RAM read strobe
//   mem_addr   result RAM read address
//   mem_rdata  result RAM data, valid the cycle after mem_rd_en
//   tx_data    byte for the Transmitter, valid while tx_load is high
//   tx_load    1-cycle load pulse to the Transmitter
//   tx_status  Transmitter ready (1 = can take a new byte)
//
// State table
//   IDLE      | waiting for start
//   LOAD_HDR  | tx_load pulse carrying SYNC_BYTE
//   FETCH     | RAM read of element elem_cnt
//   CAPTURE   | latch RAM data into the element shift register
//   LOAD_BYTE | tx_load pulse carrying the current element byte
//   WAIT_BUSY | wait for the Transmitter to drop tx_status
//   WAIT_RDY  | wait for tx_status, then choose what goes next
//   LOAD_CSUM | tx_load pulse carrying the checksum
//   FINISH    | done pulse, return to IDLE

module uart_result_streamer #(
    parameter int          ROWS      = 4,
    parameter int          COLS      = 4,
    parameter int          ELEM_W    = 16,
    parameter int          ADDR_W    = 8,
    parameter int          BASE_ADDR = 0,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ELEM_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              tx_status
);

    localparam int N_ELEM = ROWS * COLS;
    localparam int BPE    = ELEM_W / 8;
    localparam int BL_W   = $clog2(BPE + 1);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N_ELEM - 1);
    localparam logic [BL_W-1:0]   BPE_V     = BL_W'(BPE);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_HDR,
        FETCH,
        CAPTURE,
        LOAD_BYTE,
        WAIT_BUSY,
        WAIT_RDY,
        LOAD_CSUM,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] elem_cnt;
    logic [BL_W-1:0]   bytes_left;
    logic [ELEM_W-1:0] elem_sr;
    logic [7:0]        csum;
    logic              hdr_sent;
    logic              last_fetched;
    logic              csum_sent;
    logic [7:0]        cur_byte;

    assign cur_byte = elem_sr[ELEM_W-1 -: 8];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Every LOAD_* state is entered only with tx_status
    // high, so the single-cycle load always lands on a ready Transmitter.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = tx_status ? LOAD_HDR : WAIT_RDY;
                end
            end
            LOAD_HDR,
            LOAD_BYTE,
            LOAD_CSUM: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_status) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (tx_status) begin
                    if (!hdr_sent) begin
                        state_nxt = LOAD_HDR;
                    end else if (bytes_left != '0) begin
                        state_nxt = LOAD_BYTE;
                    end else if (!last_fetched) begin
                        state_nxt = FETCH;
                    end else if (!csum_sent) begin
                        state_nxt = LOAD_CSUM;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            FETCH: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // RAM data is only valid for this one cycle, so it is always
                // captured here; a busy Transmitter is waited out in WAIT_RDY.
                state_nxt = tx_status ? LOAD_BYTE : WAIT_RDY;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // Output logic
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        tx_load   = 1'b0;
        tx_data   = 8'h00;
        mem_addr  = BASE + elem_cnt;
        case (state)
            IDLE: begin
            end
            LOAD_HDR: begin
                busy    = 1'b1;
                tx_load = 1'b1;
                tx_data = SYNC_BYTE;
            end
            LOAD_BYTE: begin
                busy    = 1'b1;
                tx_load = 1'b1;
                tx_data = cur_byte;
            end
            LOAD_CSUM: begin
                busy    = 1'b1;
                tx_load = 1'b1;
                tx_data = csum;
            end
            FETCH: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Frame datapath: element counter, byte down-counter, shift register,
    // checksum and progress flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem_cnt     <= '0;
            bytes_left   <= '0;
            elem_sr      <= '0;
            csum         <= 8'h00;
            hdr_sent     <= 1'b0;
            last_fetched <= 1'b0;
            csum_sent    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        elem_cnt     <= '0;
                        bytes_left   <= '0;
                        csum         <= 8'h00;
                        hdr_sent     <= 1'b0;
                        last_fetched <= 1'b0;
                        csum_sent    <= 1'b0;
                    end
                end
                LOAD_HDR: begin
                    hdr_sent <= 1'b1;
                end
                FETCH: begin
                    // Saturate on the last element so the address never wraps.
                    if (elem_cnt == LAST_ELEM) begin
                        last_fetched <= 1'b1;
                    end else begin
                        elem_cnt <= elem_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    elem_sr    <= mem_rdata;
                    bytes_left <= BPE_V;
                end
                LOAD_BYTE: begin
                    csum       <= csum ^ cur_byte;
                    elem_sr    <= elem_sr << 8;
                    bytes_left <= bytes_left - 1'b1;
                end
                LOAD_CSUM: begin
                    csum_sent <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_streamer.sv
module tb_uart_result_streamer;

    logic        clk;
    logic        rst_n;

    // DUT 1: default 4x4 tile of 16-bit elements
    logic        start, abort;
    logic        busy, done, mem_rd_en, tx_load, tx_status;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [7:0]  tx_data;

    // DUT 2: 1x1 tile of one byte at address 3
    logic        start2, abort2;
    logic        busy2, done2, mem_rd_en2, tx_load2, tx_status2;
    logic [3:0]  mem_addr2;
    logic [7:0]  mem_rdata2;
    logic [7:0]  tx_data2;

    uart_result_streamer u_dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_load(tx_load),
        .tx_status(tx_status)
    );

    uart_result_streamer #(
        .ROWS(1), .COLS(1), .ELEM_W(8), .ADDR_W(4), .BASE_ADDR(3), .SYNC_BYTE(8'hA5)
    ) u_dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2),
        .mem_rdata(mem_rdata2), .tx_data(tx_data2), .tx_load(tx_load2),
        .tx_status(tx_status2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // RAM and Transmitter models for DUT 1
    logic [15:0] ram [16];
    logic [7:0]  byte_q [$];
    logic [7:0]  exp_q [$];
    int          tx_cnt = 0;
    logic        force_low = 1'b0;
    logic        prev_load = 1'b0;
    int          load_viol = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          oob_cnt = 0;

    assign tx_status = !force_low && (tx_cnt == 0);

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= ram[mem_addr[3:0]];
            rd_cnt    <= rd_cnt + 1;
            if (mem_addr >= 8'd16) oob_cnt <= oob_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (tx_load) begin
            if (!tx_status || prev_load) load_viol <= load_viol + 1;
            byte_q.push_back(tx_data);
            tx_cnt <= 5;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        prev_load <= tx_load;
    end

    // Models for DUT 2
    logic [7:0] byte_q2 [$];
    int         tx_cnt2 = 0;
    int         done_cnt2 = 0;
    int         rd_cnt2 = 0;
    logic [3:0] rd_addr2 = 4'h0;

    assign tx_status2 = (tx_cnt2 == 0);

    always @(posedge clk) begin
        if (mem_rd_en2) begin
            mem_rdata2 <= (mem_addr2 == 4'd3) ? 8'h3C : 8'hEE;
            rd_cnt2    <= rd_cnt2 + 1;
            rd_addr2   <= mem_addr2;
        end
        if (done2) done_cnt2 <= done_cnt2 + 1;
        if (tx_load2) begin
            byte_q2.push_back(tx_data2);
            tx_cnt2 <= 3;
        end else if (tx_cnt2 != 0) begin
            tx_cnt2 <= tx_cnt2 - 1;
        end
    end

    // Expected frame for DUT 1 built from the bench's own RAM image.
    function automatic void build_frame();
        logic [7:0] cs;
        exp_q.delete();
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ram[i][15:8]);
            exp_q.push_back(ram[i][7:0]);
            cs = cs ^ ram[i][15:8] ^ ram[i][7:0];
        end
        exp_q.push_back(cs);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n);
        for (int c = 0; c < 3000 && byte_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", mem_addr); else n_pass++;
        n_checks++; if (tx_load !== 1'b0) $display("FAIL reset_load: got %b want 0", tx_load); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data); else n_pass++;
        n_checks++; if (mem_addr2 !== 4'h3) $display("FAIL reset_addr2: got %h want 3", mem_addr2); else n_pass++;
    endtask

    task automatic test_frame();
        int d0, r0;
        logic [7:0] got;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0101 * i;
        build_frame();
        byte_q.delete();
        d0 = done_cnt; r0 = rd_cnt;
        pulse_start();
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5)
            $display("FAIL frame_latency: got load=%b data=%h want load=1 data=a5", tx_load, tx_data); else n_pass++;
        wait_done(d0);
        n_checks++; if (done_cnt !== d0 + 1) $display("FAIL frame_done: got %0d want %0d", done_cnt - d0, 1); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL frame_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (byte_q.size() !== 34) $display("FAIL frame_len: got %0d want 34", byte_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL frame_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (rd_cnt - r0 !== 16) $display("FAIL frame_reads: got %0d want 16", rd_cnt - r0); else n_pass++;
    endtask

    task automatic test_byte_order();
        int d0;
        logic [7:0] got;
        for (int i = 0; i < 16; i++) ram[i] = 16'h1234 + 16'h0111 * i;
        build_frame();
        byte_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        n_checks++; if (byte_q.size() !== 34) $display("FAIL order_len: got %0d want 34", byte_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL order_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_single();
        int d0;
        logic [7:0] want [3];
        logic [7:0] got;
        want[0] = 8'hA5; want[1] = 8'h3C; want[2] = 8'h3C;
        byte_q2.delete();
        d0 = done_cnt2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 500 && done_cnt2 == d0; c++) @(negedge clk);
        n_checks++; if (done_cnt2 !== d0 + 1) $display("FAIL single_done: got %0d want 1", done_cnt2 - d0); else n_pass++;
        n_checks++; if (byte_q2.size() !== 3) $display("FAIL single_len: got %0d want 3", byte_q2.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < byte_q2.size()) ? byte_q2[i] : 8'hxx;
            n_checks++; if (got !== want[i]) $display("FAIL single_byte%0d: got %h want %h", i, got, want[i]); else n_pass++;
        end
        n_checks++; if (rd_cnt2 !== 1) $display("FAIL single_reads: got %0d want 1", rd_cnt2); else n_pass++;
        n_checks++; if (rd_addr2 !== 4'h3) $display("FAIL single_addr: got %h want 3", rd_addr2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [7:0] got;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0101 * i;
        build_frame();
        byte_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_bytes(5);
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
        pulse_start();
        wait_done(d0);
        repeat (80) @(negedge clk);
        n_checks++; if (done_cnt !== d0 + 1) $display("FAIL b2b_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (byte_q.size() !== 34) $display("FAIL b2b_len: got %0d want 34", byte_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int d0;
        logic [7:0] got;
        byte_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_bytes(4);
        got = (byte_q.size() > 3) ? byte_q[3] : 8'hxx;
        n_checks++; if (got !== 8'h01) $display("FAIL abort_third_byte: got %h want 01", got); else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        repeat (60) @(negedge clk);
        n_checks++; if (byte_q.size() !== 4) $display("FAIL abort_no_load: got %0d bytes want 4", byte_q.size()); else n_pass++;
        n_checks++; if (done_cnt !== d0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else n_pass++;

        // start and abort together while idle: start wins
        byte_q.delete();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || tx_load !== 1'b1)
            $display("FAIL start_wins: got busy=%b load=%b want 1 1", busy, tx_load); else n_pass++;
        // abort held over the active load pulse
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || tx_load !== 1'b0)
            $display("FAIL abort_on_load: got busy=%b load=%b want 0 0", busy, tx_load); else n_pass++;
        repeat (30) @(negedge clk);
        got = (byte_q.size() > 0) ? byte_q[0] : 8'hxx;
        n_checks++; if (byte_q.size() !== 1 || got !== 8'hA5)
            $display("FAIL abort_on_load_bytes: got %0d bytes first=%h want 1 a5", byte_q.size(), got); else n_pass++;

        // recovery: a fresh frame is complete and correct
        build_frame();
        byte_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        n_checks++; if (byte_q.size() !== 34) $display("FAIL abort_recover_len: got %0d want 34", byte_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL abort_recover_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q.delete();
        pulse_start();
        wait_bytes(3);
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || mem_addr !== 8'h01)
            $display("FAIL midrst_pre: got busy=%b addr=%h want 1 01", busy, mem_addr); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, mem_rd_en, tx_load} !== 4'b0000)
            $display("FAIL midrst_ctl: got %b want 0000", {busy, done, mem_rd_en, tx_load}); else n_pass++;
        n_checks++; if (mem_addr !== 8'h00 || tx_data !== 8'h00)
            $display("FAIL midrst_bus: got addr=%h data=%h want 00 00", mem_addr, tx_data); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (tx_status !== 1'b1) $display("FAIL midrst_status: got %b want 1", tx_status); else n_pass++;
        n_checks++; if (byte_q.size() !== 3 || busy !== 1'b0)
            $display("FAIL midrst_idle: got %0d bytes busy=%b want 3 0", byte_q.size(), busy); else n_pass++;
    endtask

    task automatic test_stall();
        int d0, loads;
        logic [7:0] got;
        build_frame();
        byte_q.delete();
        d0 = done_cnt;
        force_low = 1'b1;
        pulse_start();
        loads = 0;
        for (int c = 0; c < 100; c++) begin
            if (tx_load !== 1'b0) loads++;
            @(negedge clk);
        end
        n_checks++; if (loads !== 0) $display("FAIL stall_no_load: got %0d want 0", loads); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b want 1", busy); else n_pass++;
        force_low = 1'b0;
        n_checks++; if (tx_load !== 1'b0) $display("FAIL stall_early_load: got %b want 0", tx_load); else n_pass++;
        @(negedge clk);
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5)
            $display("FAIL stall_load: got load=%b data=%h want 1 a5", tx_load, tx_data); else n_pass++;
        #4;
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5)
            $display("FAIL stall_hold: got load=%b data=%h want 1 a5", tx_load, tx_data); else n_pass++;
        wait_done(d0);
        n_checks++; if (byte_q.size() !== 34) $display("FAIL stall_len: got %0d want 34", byte_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++; if (got !== exp_q[i]) $display("FAIL stall_byte%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (load_viol !== 0) $display("FAIL load_protocol: got %0d violations want 0", load_viol); else n_pass++;
        n_checks++; if (oob_cnt !== 0) $display("FAIL oob_reads: got %0d want 0", oob_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_byte_order();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_stall();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
